imem_load_ctrl: RTL and testbench
=================================

# imem_load_ctrl

Controller that owns the single address port of the instruction memory. It shares that port between pipeline fetch and a byte-serial program loader (UART/debug side). While idle, fetch addresses pass straight through. During a load, the block stalls the pipeline, packs incoming bytes into big-endian 32-bit words and writes them to consecutive word addresses starting at 0.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address width of instruction memory (1 KiB, 256 words)
- LEN_WIDTH, ADDR_WIDTH-1, width of word-count request (covers 0..2^(ADDR_WIDTH-2))

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- ld_start  in  1  load request, sampled only in IDLE
- ld_len  in  LEN_WIDTH  number of words to load, sampled with ld_start
- ld_byte  in  8  loader byte stream data
- ld_valid  in  1  ld_byte valid
- ld_ready  out  1  controller accepts byte (transfer = ld_valid & ld_ready at rising edge)
- cpu_iaddr  in  32  fetch byte address from pipeline
- cpu_stall  out  1  freeze fetch/PC; high in every state except IDLE
- mem_addr  out  ADDR_WIDTH  byte address to instruction memory
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on load completion
- err  out  1  checksum mismatch, sticky until next accepted ld_start (0 when feature off)

## Operation
- States: IDLE, LOAD, WRITE, CSUM (only with feature), DONE.
- IDLE: mem_addr = cpu_iaddr[ADDR_WIDTH-1:0]; mem_we=0; ld_ready=0. On ld_start: latch len = min(ld_len, 2^(ADDR_WIDTH-2)); clear word_cnt, byte_cnt, sum, err.
  - len=0: go to DONE.
  - Otherwise: go to LOAD.
- LOAD: ld_ready=1. Each accepted byte shifts in MSB-first (first byte -> [31:24]); byte_cnt increments mod 4. Acceptance of the 4th byte moves to WRITE.
- WRITE: ld_ready=0; mem_we=1; mem_addr = {word_cnt, 2'b00}; mem_wdata = packed word; word_cnt++; sum += word (mod 2^32). Then:
  - word_cnt+1 == len: go to CSUM (feature on) or DONE.
  - Otherwise: return to LOAD.
- DONE: done=1, cpu_stall=1 for this cycle; next state IDLE.
- mem_addr during LOAD/CSUM/DONE = {word_cnt, 2'b00}, mem_we=0.
- ld_start outside IDLE is ignored.
- Reset mid-operation: return to IDLE. Partial word discarded, counters cleared. Words already written stay in memory.

## Timing
- Reset values: ld_ready=0, cpu_stall=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0, state IDLE.
- cpu_stall, busy, ld_ready, mem_we, done are Moore outputs decoded from registered state. cpu_stall rises the cycle after ld_start is sampled.
- Peak throughput: 1 word per 5 cycles (4 byte cycles + 1 WRITE bubble).
- Last WRITE to done pulse: 1 cycle without the feature; 4 accepted bytes + 1 cycle with it.
- cpu_stall falls the cycle after done. Fetch reads new contents from that cycle.
- Back-to-back: ld_start in the first IDLE cycle after DONE is accepted.

## Configuration
- IMEM_LOAD_CSUM_EN defined:
  - After the last WRITE, the CSUM state accepts 4 further bytes (MSB first) as expected sum.
  - err is set on the 4th byte if it differs from the 32-bit modular sum of loaded words.
  - err does not block done.
- Undefined: no CSUM state, no sum register, err tied 0.

## Structure
- Package imem_ctrl_pkg holds:
  - state enum encoding
  - IMEM_ADDR_WIDTH default (10)
  - word-shift constant (2)
- Sub-module imem_word_packer: byte shift register + 2-bit byte counter, outputs word and word_full. Reused by the CSUM state for the expected sum.

## Test plan
- Reset: hold rst low, toggle clk and cpu_iaddr=0x1C -> mem_addr=0x01C, all other outputs 0, state IDLE.
- ld_len=2, bytes 3C 01 10 01 34 3D 00 04 back-to-back -> mem_we pulses with 0x3C011001@0x000 and 0x343D0004@0x004. ld_ready low in each WRITE cycle. done 1 cycle, cpu_stall low next cycle.
- Same load with ld_valid low on alternate cycles -> identical writes. No byte lost or duplicated.
- ld_len=0 -> no mem_we, done one cycle after start sample. ld_start pulsed during LOAD -> ignored.
- rst low after 2 bytes of word 0, then new load of 1 word AABBCCDD -> single write 0xAABBCCDD@0x000.
- CSUM_EN: ld_len=2 as above, then checksum 70 3E 10 05 -> err=0. Checksum 00 00 00 00 -> err=1 until next ld_start.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared state encoding and sizing constants for the imem loader
package imem_ctrl_pkg;

    localparam int IMEM_ADDR_WIDTH = 10;
    localparam int WORD_SHIFT      = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4
    } imem_state_e;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// rtl/imem_load_ctrl_if.sv - loader byte stream, fetch address and imem write port bundle
interface imem_load_ctrl_if
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH - 1
);
    logic                  ld_start;
    logic [LEN_WIDTH-1:0]  ld_len;
    logic [7:0]            ld_byte;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [31:0]           cpu_iaddr;
    logic                  cpu_stall;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  ld_start, ld_len, ld_byte, ld_valid, cpu_iaddr,
        output ld_ready, cpu_stall, mem_addr, mem_we, mem_wdata, busy, done, err
    );

    modport master (
        output ld_start, ld_len, ld_byte, ld_valid, cpu_iaddr,
        input  ld_ready, cpu_stall, mem_addr, mem_we, mem_wdata, busy, done, err
    );

endinterface

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - shifts bytes MSB-first into a 32-bit word, flags the completing byte
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);
    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_en) begin
            r_word <= {r_word[23:0], i_byte};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    // High in the cycle whose accepted byte completes the word
    assign o_word       = r_word;
    assign o_word_full  = i_en && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - imem address-port owner: fetch pass-through or byte-serial load (IMEM_LOAD_CSUM_EN adds checksum)
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH - 1
) (
    input logic            clk,
    input logic            rst,
    imem_load_ctrl_if.slave bus
);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** (ADDR_WIDTH - WORD_SHIFT));
`ifdef IMEM_LOAD_CSUM_EN
    localparam imem_state_e ST_AFTER_LAST = ST_CSUM;
`else
    localparam imem_state_e ST_AFTER_LAST = ST_DONE;
`endif

    imem_state_e          r_state;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_word_cnt;
    logic [LEN_WIDTH-1:0] w_cnt_next;
    logic [31:0]          w_word;
    logic                 w_accept;
    logic                 w_word_full;
    logic                 w_start;
    logic                 w_unused;

    assign w_start    = (r_state == ST_IDLE) && bus.ld_start;
    assign w_accept   = bus.ld_valid && bus.ld_ready;
    assign w_cnt_next = r_word_cnt + 1'b1;

    imem_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_en        (w_accept),
        .i_byte      (bus.ld_byte),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

`ifdef IMEM_LOAD_CSUM_EN
    logic [31:0] r_sum;
    logic        r_err;
    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
`ifdef IMEM_LOAD_CSUM_EN
            r_sum      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (bus.ld_start) begin
                    r_len      <= (bus.ld_len > MAX_LEN) ? MAX_LEN : bus.ld_len;
                    r_word_cnt <= '0;
`ifdef IMEM_LOAD_CSUM_EN
                    r_sum      <= '0;
                    r_err      <= 1'b0;
`endif
                    r_state    <= (bus.ld_len == '0) ? ST_DONE : ST_LOAD;
                end
                ST_LOAD: if (w_word_full) r_state <= ST_WRITE;
                ST_WRITE: begin
                    r_word_cnt <= w_cnt_next;
`ifdef IMEM_LOAD_CSUM_EN
                    r_sum      <= r_sum + w_word;
`endif
                    r_state    <= (w_cnt_next == r_len) ? ST_AFTER_LAST : ST_LOAD;
                end
`ifdef IMEM_LOAD_CSUM_EN
                // Expected sum arrives on the same byte stream after the last word
                ST_CSUM: if (w_word_full) begin
                    r_err   <= ({w_word[23:0], bus.ld_byte} != r_sum);
                    r_state <= ST_DONE;
                end
`endif
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.cpu_stall = (r_state != ST_IDLE);
    assign bus.ld_ready  = (r_state == ST_LOAD) || (r_state == ST_CSUM);
    assign bus.mem_we    = (r_state == ST_WRITE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.mem_wdata = w_word;
    assign bus.mem_addr  = (r_state == ST_IDLE) ? bus.cpu_iaddr[ADDR_WIDTH-1:0]
                         : {r_word_cnt[ADDR_WIDTH-WORD_SHIFT-1:0], {WORD_SHIFT{1'b0}}};

    assign w_unused = ^{bus.cpu_iaddr[31:ADDR_WIDTH], r_word_cnt[LEN_WIDTH-1:ADDR_WIDTH-WORD_SHIFT]};

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - scoreboard bench for imem_load_ctrl (honours IMEM_LOAD_CSUM_EN)
module tb_imem_load_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    imem_load_ctrl_if #(.ADDR_WIDTH(10), .LEN_WIDTH(9)) bus();
    imem_load_ctrl #(.ADDR_WIDTH(10), .LEN_WIDTH(9)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor: every mem_we cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.mem_we === 1'b1) begin
            wr_t e;
            checks++;
            if (bus.ld_ready !== 1'b0) begin
                failures++;
                $display("FAIL write_ready: ld_ready=%b required 0", bus.ld_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: addr=%h data=%h required no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                    failures++;
                    $display("FAIL write: got %h@%h required %h@%h", bus.mem_wdata, bus.mem_addr, e.data, e.addr);
                end
            end
        end
    end

    task automatic start_load(input int len, input bit now);
        if (!now) @(negedge clk);
        bus.ld_start = 1'b1;
        bus.ld_len   = 9'(len);
        @(negedge clk);
        bus.ld_start = 1'b0;
        checks++;
        if (bus.cpu_stall !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_rise: cpu_stall=%b busy=%b required 1 1", bus.cpu_stall, bus.busy);
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit gaps, input int poke);
        int idx = 0;
        int cyc = 0;
        bit ph  = 1'b0;
        bit acc;
        while (idx < b.size() && cyc < 400) begin
            bus.ld_valid = gaps ? ph : 1'b1;
            ph           = ~ph;
            bus.ld_byte  = b[idx];
            bus.ld_start = (poke >= 0 && cyc == poke);
            bus.ld_len   = 9'd5;
            acc          = bus.ld_valid && bus.ld_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b0;
        checks++;
        if (idx != b.size()) begin
            failures++;
            $display("FAIL send_timeout: accepted=%0d required %0d", idx, b.size());
        end
    endtask

    task automatic wait_done(input logic exp_err);
        int n = 0;
`ifdef IMEM_LOAD_CSUM_EN
        int exp_n = 0;
`else
        int exp_n = 1;
`endif
        while (bus.done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 || n != exp_n) begin
            failures++;
            $display("FAIL done_latency: done=%b after %0d cycles required 1 after %0d", bus.done, n, exp_n);
        end
        checks++;
        if (bus.err !== exp_err) begin
            failures++;
            $display("FAIL err: err=%b required %b", bus.err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL done_release: done=%b cpu_stall=%b busy=%b required 0 0 0", bus.done, bus.cpu_stall, bus.busy);
        end
    endtask

    task automatic do_load(input logic [31:0] words[$], input bit gaps, input logic [31:0] csum,
                           input int poke, input bit now);
        logic [7:0]  b[$];
        logic [31:0] sum = 32'h0;
        logic        exp_err = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            for (int k = 3; k >= 0; k--) b.push_back(words[i][8*k +: 8]);
            exp_q.push_back('{addr: 10'(i * 4), data: words[i]});
            sum = sum + words[i];
        end
`ifdef IMEM_LOAD_CSUM_EN
        for (int k = 3; k >= 0; k--) b.push_back(csum[8*k +: 8]);
        exp_err = (csum != sum);
`endif
        start_load(words.size(), now);
        send_bytes(b, gaps, poke);
        wait_done(exp_err);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes: %0d outstanding required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.ld_start  = 1'b0;
        bus.ld_len    = '0;
        bus.ld_byte   = '0;
        bus.ld_valid  = 1'b0;
        bus.cpu_iaddr = 32'h1C;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_addr !== 10'h01C) begin failures++; $display("FAIL reset_mem_addr: %h required 01c", bus.mem_addr); end
        checks++;
        if (bus.ld_ready !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ld_ready=%b cpu_stall=%b mem_we=%b required 0 0 0", bus.ld_ready, bus.cpu_stall, bus.mem_we);
        end
        checks++;
        if (bus.mem_wdata !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: wdata=%h busy=%b done=%b err=%b required 0", bus.mem_wdata, bus.busy, bus.done, bus.err);
        end
        rst = 1'b1;
        bus.cpu_iaddr = 32'hFFFF_F3F8;
        @(negedge clk);
        checks++;
        if (bus.mem_addr !== 10'h3F8) begin failures++; $display("FAIL fetch_pass: %h required 3f8", bus.mem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[$];
        w.push_back(32'h3C01_1001);
        w.push_back(32'h343D_0004);
        do_load(w, 1'b0, 32'h703E_1005, -1, 1'b0);
        do_load(w, 1'b0, 32'h703E_1005, -1, 1'b1);
    endtask

    task automatic test_gaps();
        logic [31:0] w[$];
        w.push_back(32'h3C01_1001);
        w.push_back(32'h343D_0004);
        do_load(w, 1'b1, 32'h703E_1005, -1, 1'b0);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        bus.ld_start = 1'b1;
        bus.ld_len   = 9'd0;
        @(negedge clk);
        bus.ld_start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.cpu_stall !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_done: done=%b cpu_stall=%b required 1 1", bus.done, bus.cpu_stall);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_release: done=%b cpu_stall=%b required 0 0", bus.done, bus.cpu_stall);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] w[$];
        w.push_back(32'h1122_3344);
        do_load(w, 1'b0, 32'h1122_3344, 2, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0]  b[$];
        logic [31:0] w[$];
        b.push_back(8'h3C);
        b.push_back(8'h01);
        start_load(2, 1'b0);
        send_bytes(b, 1'b0, -1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b cpu_stall=%b ld_ready=%b required 0 0 0", bus.busy, bus.cpu_stall, bus.ld_ready);
        end
        rst = 1'b1;
        w.push_back(32'hAABB_CCDD);
        do_load(w, 1'b0, 32'hAABB_CCDD, -1, 1'b0);
    endtask

`ifdef IMEM_LOAD_CSUM_EN
    task automatic test_csum();
        logic [31:0] w[$];
        logic [31:0] one[$];
        w.push_back(32'h3C01_1001);
        w.push_back(32'h343D_0004);
        do_load(w, 1'b0, 32'h703E_1005, -1, 1'b0);
        do_load(w, 1'b0, 32'h0000_0000, -1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky: err=%b required 1", bus.err); end
        one.push_back(32'h0102_0304);
        do_load(one, 1'b0, 32'h0102_0304, -1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
`ifdef IMEM_LOAD_CSUM_EN
        test_csum();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
